// File: rtl/seg_scan_display.sv
// Time-multiplexed hex driver for a DIGITS-digit seven-segment display with decimal points.
// Outputs are registered from the scan state: one-cycle latency, no flow control.
module seg_scan_display #(
  parameter int DIGITS      = 4,
  parameter int CLK_DIV     = 50000,
  parameter int BLANK_CYC   = 500,
  parameter int SEG_ACT_LOW = 0,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4*DIGITS-1:0]   i_data,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic                  i_load,
  input  logic                  i_lz_en,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [DIGITS-1:0]     o_an
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0]     CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]     BLANK_LIM = CW'(BLANK_CYC);
  localparam logic [IW-1:0]     IDX_MAX   = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF   = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF    = (SEG_ACT_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF    = (AN_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [4*DIGITS-1:0] data_q, data_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_out_q, dp_out_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic [DIGITS-1:0]   supp;
  logic [DIGITS-1:0]   an_act;
  logic [3:0]          nib;
  logic                zero_above;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0:    hex_decode = 7'h3F;
      4'h1:    hex_decode = 7'h06;
      4'h2:    hex_decode = 7'h5B;
      4'h3:    hex_decode = 7'h4F;
      4'h4:    hex_decode = 7'h66;
      4'h5:    hex_decode = 7'h6D;
      4'h6:    hex_decode = 7'h7D;
      4'h7:    hex_decode = 7'h07;
      4'h8:    hex_decode = 7'h7F;
      4'h9:    hex_decode = 7'h6F;
      4'hA:    hex_decode = 7'h77;
      4'hB:    hex_decode = 7'h7C;
      4'hC:    hex_decode = 7'h39;
      4'hD:    hex_decode = 7'h5E;
      4'hE:    hex_decode = 7'h79;
      default: hex_decode = 7'h71;
    endcase
  endfunction

  // A digit is a leading zero when it and every more-significant digit show 0 with no dp.
  always_comb begin
    supp       = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (data_q[4*k +: 4] == 4'h0) & ~dp_q[k];
      supp[k]    = zero_above & (k != 0);
    end
  end

  always_comb begin
    data_d = data_q;
    dp_d   = dp_q;
    cnt_d  = cnt_q + CW'(1);
    idx_d  = idx_q;
    if (i_load) begin
      data_d = i_data;
      dp_d   = i_dp;
    end
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
  end

  always_comb begin
    nib         = data_q[{idx_q, 2'b00} +: 4];
    an_act      = '0;
    an_act[idx_q] = 1'b1;
    an_d        = AN_OFF;
    seg_d       = SEG_OFF;
    dp_out_d    = DP_OFF;
    if (cnt_q >= BLANK_LIM) begin
      an_d     = an_act ^ AN_OFF;
      seg_d    = ((i_lz_en && supp[idx_q]) ? 7'h00 : hex_decode(nib)) ^ SEG_OFF;
      dp_out_d = dp_q[idx_q] ^ DP_OFF;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q   <= '0;
      dp_q     <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_OFF;
      dp_out_q <= DP_OFF;
      an_q     <= AN_OFF;
    end else begin
      data_q   <= data_d;
      dp_q     <= dp_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      dp_out_q <= dp_out_d;
      an_q     <= an_d;
    end
  end

  assign o_seg = seg_q;
  assign o_dp  = dp_out_q;
  assign o_an  = an_q;

endmodule
